// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns PCF, talks to instruction memory with a
// request/ready handshake, and drives the IF/ID pipeline register.
module fetch_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   output logic [XLEN-1:0] IAddr,
   output logic            IReq,
   input  logic            IReady,
   input  logic [XLEN-1:0] IRData,
   input  logic            StallD,
   input  logic            FlushD,
   input  logic            RedirectValid,
   input  logic [XLEN-1:0] RedirectPC,
   output logic [XLEN-1:0] InstrD,
   output logic [XLEN-1:0] PCPlus8D,
   output logic            ValidD,
   output logic [XLEN-1:0] PCF
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      DROP  = 2'd1,   // request in flight whose response must be discarded
      HOLD  = 2'd2    // response captured while decode was stalled
   } state_t;

   state_t          state, state_n;
   logic [XLEN-1:0] pcf_n;
   logic [XLEN-1:0] pend_pc, pend_pc_n;
   logic [XLEN-1:0] hold_instr, hold_instr_n;
   logic [XLEN-1:0] hold_pc8, hold_pc8_n;
   logic            load;
   logic [XLEN-1:0] load_instr, load_pc8;
   logic [XLEN-1:0] redirect_pc;

   // Word-align the redirect target by masking the low two bits.
   assign redirect_pc = RedirectPC & ~XLEN'(3);

   assign IAddr = PCF;
   assign IReq  = !reset && (state != HOLD);

   always_comb begin
      // NOTE: every signal gets a default before the case so no path can
      // leave it unassigned and infer a latch.
      state_n      = state;
      pcf_n        = PCF;
      pend_pc_n    = pend_pc;
      hold_instr_n = hold_instr;
      hold_pc8_n   = hold_pc8;
      load         = 1'b0;
      load_instr   = IRData;
      load_pc8     = PCF + XLEN'(8);

      case (state)
         FETCH: begin
            if (RedirectValid) begin
               if (IReady) begin
                  pcf_n = redirect_pc;
               end else begin
                  // Address must stay put until the outstanding request returns.
                  pend_pc_n = redirect_pc;
                  state_n   = DROP;
               end
            end else if (IReady) begin
               pcf_n = PCF + XLEN'(4);
               if (StallD) begin
                  hold_instr_n = IRData;
                  hold_pc8_n   = PCF + XLEN'(8);
                  state_n      = HOLD;
               end else begin
                  load = 1'b1;
               end
            end
         end

         DROP: begin
            if (RedirectValid) pend_pc_n = redirect_pc;
            if (IReady) begin
               pcf_n   = RedirectValid ? redirect_pc : pend_pc;
               state_n = FETCH;
            end
         end

         HOLD: begin
            if (RedirectValid) begin
               pcf_n   = redirect_pc;
               state_n = FETCH;
            end else if (!StallD) begin
               load       = 1'b1;
               load_instr = hold_instr;
               load_pc8   = hold_pc8;
               state_n    = FETCH;
            end
         end

         default: state_n = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      if (reset) begin
         state      <= FETCH;
         PCF        <= RESET_PC;
         pend_pc    <= '0;
         hold_instr <= '0;
         hold_pc8   <= '0;
         InstrD     <= '0;
         PCPlus8D   <= '0;
         ValidD     <= 1'b0;
      end else begin
         state      <= state_n;
         PCF        <= pcf_n;
         pend_pc    <= pend_pc_n;
         hold_instr <= hold_instr_n;
         hold_pc8   <= hold_pc8_n;
         // IF/ID register: flush beats stall beats load; otherwise a bubble.
         if (FlushD) begin
            InstrD <= '0;
            ValidD <= 1'b0;
         end else if (!StallD) begin
            if (load) begin
               InstrD   <= load_instr;
               PCPlus8D <= load_pc8;
               ValidD   <= 1'b1;
            end else begin
               ValidD <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; memory returns addr ^ 0xE0000000
// unless an explicit data word is forced.
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] IAddr;
   logic        IReq;
   logic        IReady;
   logic [31:0] IRData;
   logic        StallD;
   logic        FlushD;
   logic        RedirectValid;
   logic [31:0] RedirectPC;
   logic [31:0] InstrD;
   logic [31:0] PCPlus8D;
   logic        ValidD;
   logic [31:0] PCF;

   logic        use_ovr;
   logic [31:0] ovr_data;
   int          errors = 0;
   int          checks = 0;

   fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0100)) dut (
      .clk(clk), .reset(reset), .IAddr(IAddr), .IReq(IReq), .IReady(IReady),
      .IRData(IRData), .StallD(StallD), .FlushD(FlushD),
      .RedirectValid(RedirectValid), .RedirectPC(RedirectPC),
      .InstrD(InstrD), .PCPlus8D(PCPlus8D), .ValidD(ValidD), .PCF(PCF)
   );

   always #5 clk = ~clk;

   assign IRData = use_ovr ? ovr_data : (IAddr ^ 32'hE000_0000);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; IReady = 1'b1; StallD = 1'b0; FlushD = 1'b0;
      RedirectValid = 1'b0; RedirectPC = '0; use_ovr = 1'b0; ovr_data = '0;

      // Reset state
      step();
      check("rst_pcf",    PCF,      32'h100);
      check("rst_ireq",   {31'b0, IReq},   32'h0);
      check("rst_valid",  {31'b0, ValidD}, 32'h0);
      check("rst_instr",  InstrD,   32'h0);
      check("rst_pc8",    PCPlus8D, 32'h0);
      reset = 1'b0;
      #1;
      check("seq_ireq0",  {31'b0, IReq}, 32'h1);
      check("seq_iaddr0", IAddr, 32'h100);

      // Back-to-back fetch, one instruction per cycle
      step();
      check("seq_instr0", InstrD,   32'hE000_0100);
      check("seq_valid0", {31'b0, ValidD}, 32'h1);
      check("seq_pc8_0",  PCPlus8D, 32'h108);
      check("seq_iaddr1", IAddr,    32'h104);
      step();
      check("seq_instr1", InstrD,   32'hE000_0104);
      check("seq_pc8_1",  PCPlus8D, 32'h10C);
      check("seq_iaddr2", IAddr,    32'h108);
      step();
      check("seq_instr2", InstrD,   32'hE000_0108);
      check("seq_pc8_2",  PCPlus8D, 32'h110);

      // Redirect with IReady high: fetched word dropped, target next
      RedirectValid = 1'b1; RedirectPC = 32'h20;
      step();
      RedirectValid = 1'b0;
      check("rd_bubble",  {31'b0, ValidD}, 32'h0);
      check("rd_iaddr",   IAddr, 32'h20);

      // Memory not ready for three cycles
      IReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("wait_iaddr", IAddr, 32'h20);
         check("wait_ireq",  {31'b0, IReq},   32'h1);
         check("wait_valid", {31'b0, ValidD}, 32'h0);
      end
      IReady = 1'b1; use_ovr = 1'b1; ovr_data = 32'hE281_1001;
      step();
      use_ovr = 1'b0;
      check("wait_instr", InstrD,   32'hE281_1001);
      check("wait_valid1", {31'b0, ValidD}, 32'h1);
      check("wait_pc8",   PCPlus8D, 32'h28);
      check("wait_next",  IAddr,    32'h24);

      // Redirect while a request is outstanding
      RedirectValid = 1'b1; RedirectPC = 32'h40;
      step();
      check("drop_at40", IAddr, 32'h40);
      IReady = 1'b0; RedirectPC = 32'h400;
      step();
      RedirectValid = 1'b0;
      check("drop_hold1", IAddr, 32'h40);
      check("drop_valid1", {31'b0, ValidD}, 32'h0);
      step();
      check("drop_hold2", IAddr, 32'h40);
      check("drop_ireq",  {31'b0, IReq}, 32'h1);
      IReady = 1'b1;
      step();
      check("drop_valid2", {31'b0, ValidD}, 32'h0);
      check("drop_target", IAddr, 32'h400);
      step();
      check("drop_instr", InstrD, 32'hE000_0400);
      check("drop_valid3", {31'b0, ValidD}, 32'h1);

      // Decode stall while the response for 0x80 arrives
      RedirectValid = 1'b1; RedirectPC = 32'h80;
      step();
      RedirectValid = 1'b0;
      check("stall_at80", IAddr, 32'h80);
      StallD = 1'b1;
      step();
      check("stall_ireq1",  {31'b0, IReq}, 32'h0);
      check("stall_instr1", InstrD, 32'hE000_0400);
      check("stall_pcf",    PCF, 32'h84);
      step();
      check("stall_ireq2",  {31'b0, IReq}, 32'h0);
      check("stall_instr2", InstrD, 32'hE000_0400);
      StallD = 1'b0;
      step();
      check("rel_instr", InstrD,   32'hE000_0080);
      check("rel_pc8",   PCPlus8D, 32'h88);
      check("rel_valid", {31'b0, ValidD}, 32'h1);
      check("rel_iaddr", IAddr,    32'h84);
      check("rel_ireq",  {31'b0, IReq}, 32'h1);

      // Flush overrides stall; redirect in HOLD drops the buffered word
      FlushD = 1'b1; StallD = 1'b1;
      step();
      FlushD = 1'b0;
      check("flush_valid", {31'b0, ValidD}, 32'h0);
      check("flush_instr", InstrD, 32'h0);
      check("flush_ireq",  {31'b0, IReq}, 32'h0);
      RedirectValid = 1'b1; RedirectPC = 32'h300;
      step();
      RedirectValid = 1'b0;
      check("hrd_iaddr", IAddr, 32'h300);
      check("hrd_ireq",  {31'b0, IReq}, 32'h1);
      StallD = 1'b0;
      step();
      check("hrd_instr", InstrD, 32'hE000_0300);
      check("hrd_valid", {31'b0, ValidD}, 32'h1);

      // PC wrap-around and redirect alignment
      RedirectValid = 1'b1; RedirectPC = 32'hFFFF_FFFC;
      step();
      RedirectValid = 1'b0;
      check("wrap_at",  IAddr, 32'hFFFF_FFFC);
      step();
      check("wrap_next",  IAddr,    32'h0);
      check("wrap_instr", InstrD,   32'h1FFF_FFFC);
      check("wrap_pc8",   PCPlus8D, 32'h4);
      RedirectValid = 1'b1; RedirectPC = 32'h203;
      step();
      RedirectValid = 1'b0;
      check("align_iaddr", IAddr, 32'h200);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
